// File: rtl/mult4_seq_ctrl.sv
// Sequential 4x4 unsigned shift-add multiplier: one partial product per STEP_DIV cycles.
// Define MULT4_SEQ_START_EDGE_EN to synchronise start and act only on its rising edge.
module mult4_seq_ctrl #(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    output logic [7:0]  p,
    output logic        busy,
    output logic        done,
    output logic [15:0] x,
    output logic [1:0]  state_dbg
);

    // Handshake: start is a request that is honoured only in IDLE; busy is high from
    // the capture edge until the edge after the single-cycle done pulse.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

    state_t      state_q;
    logic [3:0]  a_q;
    logic [3:0]  b_q;
    logic [7:0]  acc_q;
    logic [7:0]  p_q;
    logic [1:0]  k_q;
    logic [15:0] div_q;
    logic        busy_q;
    logic        done_q;
    logic        start_qual;
    logic [7:0]  addend_d;
    logic [7:0]  acc_d;

`ifdef MULT4_SEQ_START_EDGE_EN
    // [0],[1] form the synchroniser; [2] remembers the previous synchronised level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], start};
        end
    end

    assign start_qual = sync_q[1] & ~sync_q[2];
`else
    assign start_qual = start;
`endif

    always_comb begin
        addend_d = 8'd0;
        if (b_q[k_q]) begin
            addend_d = {4'b0000, a_q} << k_q;
        end
        acc_d = acc_q + addend_d;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            acc_q   <= 8'd0;
            p_q     <= 8'd0;
            k_q     <= 2'd0;
            div_q   <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_qual) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= 8'd0;
                        k_q     <= 2'd0;
                        div_q   <= 16'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= 16'd0;
                        acc_q <= acc_d;
                        k_q   <= k_q + 2'd1;
                        // p only ever sees the finished sum, never a partial one.
                        if (k_q == 2'd3) begin
                            p_q     <= acc_d;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p         = p_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign x         = {a_q, b_q, p_q};
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed bench for mult4_seq_ctrl: STEP_DIV=1 and STEP_DIV=3 instances share clk and clr.
module tb_mult4_seq_ctrl;

`ifdef MULT4_SEQ_START_EDGE_EN
    localparam int OFS = 2;
`else
    localparam int OFS = 0;
`endif

    logic        clk;
    logic        clr;
    logic        start1, start3;
    logic [3:0]  a1, b1, a3, b3;
    logic [7:0]  p1, p3;
    logic        busy1, busy3, done1, done3;
    logic [15:0] x1, x3;
    logic [1:0]  st1, st3;

    int n_cmp;
    int n_bad;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mult4_seq_ctrl #(.STEP_DIV(1)) u1 (
        .clk(clk), .clr(clr), .start(start1), .a(a1), .b(b1),
        .p(p1), .busy(busy1), .done(done1), .x(x1), .state_dbg(st1)
    );

    mult4_seq_ctrl #(.STEP_DIV(3)) u3 (
        .clk(clk), .clr(clr), .start(start3), .a(a3), .b(b3),
        .p(p3), .busy(busy3), .done(done3), .x(x3), .state_dbg(st3)
    );

    task automatic test_reset();
        clr = 1'b0;
        start1 = 1'b0; start3 = 1'b0;
        a1 = 4'd0; b1 = 4'd0; a3 = 4'd0; b3 = 4'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (p1 !== 8'h00) begin n_bad++; $display("FAIL reset_p got %h want 00", p1); end
        n_cmp++;
        if (x1 !== 16'h0000) begin n_bad++; $display("FAIL reset_x got %h want 0000", x1); end
        n_cmp++;
        if ({busy1, done1, busy3, done3} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got %b want 0000", {busy1, done1, busy3, done3});
        end
        clr = 1'b1;
        @(negedge clk);
    endtask

    // One start pulse on u1; operands are scrambled mid-run to prove they were captured.
    task automatic test_op(input logic [3:0] av, input logic [3:0] bv,
                           input logic [7:0] ep, input string nm);
        int done_at, done_cnt, busy_cnt;
        logic [7:0] p_at;
        logic [15:0] x_at;
        done_at = 0; done_cnt = 0; busy_cnt = 0; p_at = 8'h00; x_at = 16'h0000;
        @(negedge clk);
        a1 = av; b1 = bv; start1 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start1 = 1'b0;
            if (i == 2) begin a1 = ~av; b1 = ~bv; end
            busy_cnt += int'(busy1);
            if (done1) begin
                done_cnt++;
                if (done_at == 0) begin done_at = i; p_at = p1; x_at = x1; end
            end
        end
        n_cmp++;
        if (done_at !== OFS + 5) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", nm, done_at, OFS + 5); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_cnt got %0d want 1", nm, done_cnt); end
        n_cmp++;
        if (busy_cnt !== 5) begin n_bad++; $display("FAIL %s_busy_cycles got %0d want 5", nm, busy_cnt); end
        n_cmp++;
        if (p_at !== ep) begin n_bad++; $display("FAIL %s_p got %h want %h", nm, p_at, ep); end
        n_cmp++;
        if (x_at !== {av, bv, ep}) begin n_bad++; $display("FAIL %s_x got %h want %h", nm, x_at, {av, bv, ep}); end
        n_cmp++;
        if (p1 !== ep) begin n_bad++; $display("FAIL %s_p_hold got %h want %h", nm, p1, ep); end
    endtask

    task automatic test_step_div3();
        int done_at;
        logic [7:0] p_at;
        logic [15:0] x_at;
        done_at = 0; p_at = 8'h00; x_at = 16'h0000;
        @(negedge clk);
        a3 = 4'd7; b3 = 4'd6; start3 = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 1) start3 = 1'b0;
            if (i == 5) a3 = 4'd1;
            if (done3 && done_at == 0) begin done_at = i; p_at = p3; x_at = x3; end
        end
        n_cmp++;
        if (done_at !== OFS + 13) begin n_bad++; $display("FAIL div3_latency got %0d want %0d", done_at, OFS + 13); end
        n_cmp++;
        if (p_at !== 8'h2A) begin n_bad++; $display("FAIL div3_p got %h want 2a", p_at); end
        n_cmp++;
        if (x_at[15:12] !== 4'd7) begin n_bad++; $display("FAIL div3_a_reg got %h want 7", x_at[15:12]); end
    endtask

    task automatic test_start_while_busy();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        a1 = 4'd5; b1 = 4'd4; start1 = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) start1 = 1'b0;
            if (i == 3) begin a1 = 4'd1; b1 = 4'd1; start1 = 1'b1; end
            if (i == 4) start1 = 1'b0;
            if (done1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_start_done_cnt got %0d want 1", done_cnt); end
        n_cmp++;
        if (p1 !== 8'h14) begin n_bad++; $display("FAIL busy_start_p got %h want 14", p1); end
    endtask

    task automatic test_clr_abort();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        a1 = 4'd15; b1 = 4'd15; start1 = 1'b1;
        for (int i = 1; i <= OFS + 3; i++) begin
            @(negedge clk);
            if (i == 1) start1 = 1'b0;
            if (done1) done_cnt++;
        end
        clr = 1'b0;
        #1;
        n_cmp++;
        if ({busy1, done1} !== 2'b00) begin n_bad++; $display("FAIL abort_flags got %b want 00", {busy1, done1}); end
        n_cmp++;
        if (p1 !== 8'h00) begin n_bad++; $display("FAIL abort_p got %h want 00", p1); end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done_cnt got %0d want 0", done_cnt); end
        test_op(4'd2, 4'd3, 8'h06, "after_abort");
    endtask

    task automatic test_back_to_back();
        int done_cnt, first_at, second_at;
        done_cnt = 0; first_at = 0; second_at = 0;
        @(negedge clk);
        a1 = 4'd2; b1 = 4'd2; start1 = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 20) start1 = 1'b0;
            if (done1) begin
                done_cnt++;
                if (done_cnt == 1) first_at = i;
                if (done_cnt == 2) second_at = i;
            end
        end
`ifdef MULT4_SEQ_START_EDGE_EN
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL hold_done_cnt got %0d want 1", done_cnt); end
`else
        n_cmp++;
        if (done_cnt !== 4) begin n_bad++; $display("FAIL hold_done_cnt got %0d want 4", done_cnt); end
        n_cmp++;
        if (second_at - first_at !== 6) begin
            n_bad++; $display("FAIL hold_done_period got %0d want 6", second_at - first_at);
        end
`endif
        n_cmp++;
        if (first_at !== OFS + 5) begin n_bad++; $display("FAIL hold_first_done got %0d want %0d", first_at, OFS + 5); end
        n_cmp++;
        if (p1 !== 8'h04) begin n_bad++; $display("FAIL hold_p got %h want 04", p1); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_op(4'd3, 4'd5, 8'h0F, "mul_3x5");
        test_op(4'd15, 4'd15, 8'hE1, "mul_15x15");
        test_op(4'd0, 4'd9, 8'h00, "mul_0x9");
        test_op(4'd9, 4'd0, 8'h00, "mul_9x0");
        test_step_div3();
        test_start_while_busy();
        test_clr_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
